// File: rtl/hilo_wb_stage.sv
// Writeback stage: HI/LO architectural registers plus a 2-entry skid buffer (EMPTY/ONE/FULL).
// Latency 1 cycle; in_ready is registered (low only when FULL), so out_ready has no combinational path to it.
module hilo_wb_stage #(
    parameter logic [31:0] HILO_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  FS,
    input  logic [31:0] Y_hi,
    input  logic [31:0] Y_lo,
    input  logic        C,
    input  logic        V,
    input  logic        N,
    input  logic        Z,
    input  logic [1:0]  y_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] D_out,
    output logic        C_out,
    output logic        V_out,
    output logic        N_out,
    output logic        Z_out,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } ent_t;

    state_t      state_q, state_d;
    ent_t        head_q, head_d;
    ent_t        tail_q, tail_d;
    ent_t        new_ent;
    logic        in_ready_q;
    logic [31:0] hi_d, lo_d;
    logic        accept, pop, hilo_wr;

    assign accept  = in_valid & in_ready_q;
    assign pop     = (state_q != EMPTY) & out_ready;
    assign hilo_wr = accept & ((FS == 6'h1E) | (FS == 6'h1F));

    // MFHI/MFLO read the pre-update HI/LO, so a MUL/DIV that also moves-from sees the old value.
    always_comb begin
        new_ent = '{d: Y_lo, c: C, v: V, n: N, z: Z};
        if (y_sel == 2'b01 || y_sel == 2'b10) begin
            new_ent.d = (y_sel == 2'b01) ? HI_q : LO_q;
            new_ent.c = 1'b0;
            new_ent.v = 1'b0;
            new_ent.n = new_ent.d[31];
            new_ent.z = (new_ent.d == 32'h0);
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        hi_d    = hilo_wr ? Y_hi : HI_q;
        lo_d    = hilo_wr ? Y_lo : LO_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = new_ent;
                end else if (accept) begin
                    tail_d  = new_ent;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            HI_q       <= HILO_RST;
            LO_q       <= HILO_RST;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != FULL);
            HI_q       <= hi_d;
            LO_q       <= lo_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign D_out     = head_q.d;
    assign C_out     = head_q.c;
    assign V_out     = head_q.v;
    assign N_out     = head_q.n;
    assign Z_out     = head_q.z;

endmodule

// File: tb/tb_hilo_wb_stage.sv
// Directed bench for hilo_wb_stage: a driver pushes hand-computed expected beats into a
// scoreboard queue, and an independent monitor pops and compares every delivered beat.
module tb_hilo_wb_stage;

    localparam logic [31:0] RST_V = 32'h1234_5678;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  FS;
    logic [31:0] Y_hi, Y_lo, D_out, HI_q, LO_q;
    logic        C, V, N, Z, C_out, V_out, N_out, Z_out;
    logic [1:0]  y_sel;

    logic [35:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    hilo_wb_stage #(.HILO_RST(RST_V)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .Y_hi(Y_hi), .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z), .y_sel(y_sel),
        .out_valid(out_valid), .out_ready(out_ready), .D_out(D_out),
        .C_out(C_out), .V_out(V_out), .N_out(N_out), .Z_out(Z_out),
        .HI_q(HI_q), .LO_q(LO_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // exp = {D, C, V, N, Z}; the beat is held on the inputs until accepted.
    task automatic send(input logic [5:0] fs, input logic [31:0] yhi, input logic [31:0] ylo,
                        input logic [3:0] cvnz, input logic [1:0] ys, input logic [35:0] exp);
        logic got;
        got = 1'b0;
        in_valid = 1'b1; FS = fs; Y_hi = yhi; Y_lo = ylo;
        {C, V, N, Z} = cvnz; y_sel = ys;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 36'd0, 36'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {D_out, C_out, V_out, N_out, Z_out}, 36'hx);
            end else begin
                chk("beat", {D_out, C_out, V_out, N_out, Z_out}, sb.pop_front());
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", 36'(sb.size()), 36'd0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        FS = '0; Y_hi = '0; Y_lo = '0; {C, V, N, Z} = 4'b0; y_sel = 2'b00;
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready", 36'(in_ready), 36'd0);
        chk("rst_out_valid", 36'(out_valid), 36'd0);
        chk("rst_dout_flags", {D_out, C_out, V_out, N_out, Z_out}, 36'd0);
        chk("rst_hi_lo", {4'd0, HI_q}, {4'd0, RST_V});
        chk("rst_lo", {4'd0, LO_q}, {4'd0, RST_V});
        #21 reset = 1'b0;
        #1 chk("in_ready_before_edge", 36'(in_ready), 36'd0);
        @(posedge clk); #1;
        chk("in_ready_after_edge", 36'(in_ready), 36'd1);

        // MUL then MFHI back to back
        out_ready = 1'b1;
        send(6'h1E, 32'h1, 32'h8000_0000, 4'b0010, 2'b00, {32'h8000_0000, 4'b0010});
        send(6'h00, 32'h0, 32'hAAAA_AAAA, 4'b1111, 2'b01, {32'h1, 4'b0000});
        chk("mul_hi", {4'd0, HI_q}, 36'h1);
        chk("mul_lo", {4'd0, LO_q}, 36'h8000_0000);

        // DIV with zero quotient, then MFLO and MFHI
        send(6'h1F, 32'h7, 32'h0, 4'b0001, 2'b00, {32'h0, 4'b0001});
        send(6'h00, 32'h0, 32'h5555, 4'b1110, 2'b10, {32'h0, 4'b0001});
        send(6'h00, 32'h0, 32'h5555, 4'b1111, 2'b01, {32'h7, 4'b0000});

        // MUL that also reads HI sees the old value; later reads see the new one
        send(6'h1E, 32'hFFFF_0000, 32'h5, 4'b0000, 2'b01, {32'h7, 4'b0000});
        send(6'h00, 32'h0, 32'h0, 4'b0000, 2'b01, {32'hFFFF_0000, 4'b0010});
        send(6'h00, 32'h0, 32'h0, 4'b0000, 2'b10, {32'h5, 4'b0000});
        send(6'h00, 32'h0, 32'hCAFE, 4'b1001, 2'b11, {32'hCAFE, 4'b1001});
        drain();

        // Backpressure: fill, stall a MUL upstream, then release
        out_ready = 1'b0;
        send(6'h00, 32'h0, 32'd10, 4'b0000, 2'b00, {32'd10, 4'b0000});
        send(6'h00, 32'h0, 32'd11, 4'b0000, 2'b00, {32'd11, 4'b0000});
        chk("full_in_ready", 36'(in_ready), 36'd0);
        fork
            send(6'h1E, 32'h99, 32'd12, 4'b0000, 2'b00, {32'd12, 4'b0000});
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_hi", {4'd0, HI_q}, 36'hFFFF_0000);
                chk("stall_lo", {4'd0, LO_q}, 36'h5);
                out_ready = 1'b1;
            end
        join
        chk("stall_mul_hi", {4'd0, HI_q}, 36'h99);
        chk("stall_mul_lo", {4'd0, LO_q}, 36'd12);
        drain();

        // Accept and pop together in ONE
        send(6'h00, 32'h0, 32'd5, 4'b0000, 2'b00, {32'd5, 4'b0000});
        send(6'h00, 32'h0, 32'd6, 4'b0000, 2'b00, {32'd6, 4'b0000});
        chk("one_swap_dout", {4'd0, D_out}, 36'd6);
        chk("one_swap_in_ready", 36'(in_ready), 36'd1);
        drain();

        // Head holds while stalled
        out_ready = 1'b0;
        send(6'h00, 32'h0, 32'h77, 4'b0100, 2'b00, {32'h77, 4'b0100});
        repeat (3) @(posedge clk);
        #1 chk("hold_head", {D_out, C_out, V_out, N_out, Z_out}, {32'h77, 4'b0100});
        out_ready = 1'b1;
        drain();

        // Async reset while FULL, between clock edges
        out_ready = 1'b0;
        send(6'h1E, 32'h33, 32'h21, 4'b0000, 2'b00, {32'h21, 4'b0000});
        send(6'h00, 32'h0, 32'h22, 4'b0000, 2'b00, {32'h22, 4'b0000});
        sb.delete();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 36'(out_valid), 36'd0);
        chk("mid_rst_in_ready", 36'(in_ready), 36'd0);
        chk("mid_rst_hi", {4'd0, HI_q}, {4'd0, RST_V});
        chk("mid_rst_lo", {4'd0, LO_q}, {4'd0, RST_V});
        chk("mid_rst_dout", {D_out, C_out, V_out, N_out, Z_out}, 36'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(6'h00, 32'h0, 32'h0, 4'b1111, 2'b01, {RST_V, 4'b0000});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
